// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared widths, reset PC and bus field layouts for the IF/ID boundary
package if_stage_pkg;

    localparam logic [31:0] RESET_PC        = 32'h1c000000;
    localparam int          FS_TO_DS_BUS_WD = 65;
    localparam int          BR_BUS_WD       = 34;

    localparam int FS_PC_LSB     = 0;
    localparam int FS_INST_LSB   = 32;
    localparam int FS_ADEF_BIT   = 64;
    localparam int BR_TARGET_LSB = 0;
    localparam int BR_TAKEN_BIT  = 32;
    localparam int BR_STALL_BIT  = 33;

    typedef struct packed {
        logic        stall;
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    typedef struct packed {
        logic        adef;
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_t;

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: IF-stage handshake towards ID, redirect bus from ID and instruction SRAM port
interface if_stage_if;
    import if_stage_pkg::*;

    logic                       ds_allowin;
    logic [BR_BUS_WD-1:0]       br_bus;
    logic                       fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
    logic                       inst_sram_en;
    logic [3:0]                 inst_sram_we;
    logic [31:0]                inst_sram_addr;
    logic [31:0]                inst_sram_wdata;
    logic [31:0]                inst_sram_rdata;

    modport master (
        input  ds_allowin, br_bus, inst_sram_rdata,
        output fs_to_ds_valid, fs_to_ds_bus,
               inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );

    modport slave (
        output ds_allowin, br_bus, inst_sram_rdata,
        input  fs_to_ds_valid, fs_to_ds_bus,
               inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );

endinterface

// File: rtl/if_stage.sv
// if_stage: owns the PC, fetches from instruction SRAM and hands {adef, inst, pc} to ID
module if_stage
    import if_stage_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    if_stage_if.master bus
);

    br_bus_t     br;
    logic        fs_allowin, req;
    logic [31:0] nextpc, fs_inst;

    logic        to_fs_valid_q, to_fs_valid_d;
    logic        fs_valid_q, fs_valid_d;
    logic        fs_adef_q, fs_adef_d;
    logic [31:0] fs_pc_q, fs_pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        br_pending_q, br_pending_d;
    logic [31:0] br_pending_target_q, br_pending_target_d;

    assign br = br_bus_t'(bus.br_bus);

    // fetch request and next-PC selection: live redirect beats a deferred one beats sequential
    always_comb begin
        fs_allowin = ~fs_valid_q | bus.ds_allowin;
        req        = to_fs_valid_q & fs_allowin & ~br.stall;
        nextpc     = br.taken ? br.target : br_pending_q ? br_pending_target_q : fs_pc_q + 32'd4;
        fs_inst    = fs_adef_q ? 32'b0 : buf_valid_q ? inst_buf_q : bus.inst_sram_rdata;
    end

    // next state: a taken branch squashes the IF slot; SRAM data is parked while ID stalls
    always_comb begin
        to_fs_valid_d       = 1'b1;
        fs_valid_d          = fs_allowin ? req : fs_valid_q & ~br.taken;
        fs_pc_d             = req ? nextpc : fs_pc_q;
        fs_adef_d           = req ? (nextpc[1:0] != 2'b00) : fs_adef_q;
        buf_valid_d         = (br.taken | (fs_valid_q & bus.ds_allowin)) ? 1'b0 :
                              (fs_valid_q & ~bus.ds_allowin) ? 1'b1 : buf_valid_q;
        inst_buf_d          = (fs_valid_q & ~bus.ds_allowin & ~buf_valid_q) ? bus.inst_sram_rdata : inst_buf_q;
        br_pending_d        = req ? 1'b0 : br.taken ? 1'b1 : br_pending_q;
        br_pending_target_d = (~req & br.taken) ? br.target : br_pending_target_q;
    end

    // state registers, cleared asynchronously so outputs drop as soon as reset asserts
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_fs_valid_q       <= 1'b0;
            fs_valid_q          <= 1'b0;
            fs_adef_q           <= 1'b0;
            fs_pc_q             <= RESET_PC - 32'd4;
            buf_valid_q         <= 1'b0;
            inst_buf_q          <= 32'b0;
            br_pending_q        <= 1'b0;
            br_pending_target_q <= 32'b0;
        end else begin
            to_fs_valid_q       <= to_fs_valid_d;
            fs_valid_q          <= fs_valid_d;
            fs_adef_q           <= fs_adef_d;
            fs_pc_q             <= fs_pc_d;
            buf_valid_q         <= buf_valid_d;
            inst_buf_q          <= inst_buf_d;
            br_pending_q        <= br_pending_d;
            br_pending_target_q <= br_pending_target_d;
        end
    end

    assign bus.inst_sram_en    = req & (nextpc[1:0] == 2'b00);
    assign bus.inst_sram_we    = 4'b0;
    assign bus.inst_sram_addr  = nextpc;
    assign bus.inst_sram_wdata = 32'b0;
    assign bus.fs_to_ds_valid  = fs_valid_q & ~br.taken;
    assign bus.fs_to_ds_bus    = {fs_adef_q, fs_inst, fs_pc_q};

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vector table plus randomized run against a delivery-order model
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] R = 32'h1c000000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    if_stage_if bus_if();

    if_stage dut (.clk(clk), .resetn(resetn), .bus(bus_if));

    always #5 clk = ~clk;

    // SRAM returns the requested address as data; without a request it returns garbage
    always @(posedge clk) bus_if.inst_sram_rdata <= bus_if.inst_sram_en ? bus_if.inst_sram_addr : $urandom;

    typedef struct {
        logic        rst_n, allow, stall, taken;
        logic [31:0] target;
        logic [4:0]  m;
        logic        en;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc, inst;
        logic        adef;
    } vec_t;

    function automatic vec_t v(logic rst_n, logic allow, logic stall, logic taken, logic [31:0] target,
                               logic [4:0] m, logic en, logic [31:0] addr, logic valid,
                               logic [31:0] pc, logic [31:0] inst, logic adef);
        vec_t r;
        r.rst_n = rst_n; r.allow = allow; r.stall = stall; r.taken = taken; r.target = target;
        r.m = m; r.en = en; r.addr = addr; r.valid = valid; r.pc = pc; r.inst = inst; r.adef = adef;
        return r;
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic allow, input logic stall, input logic taken, input logic [31:0] tgt);
        bus_if.ds_allowin = allow;
        bus_if.br_bus     = {stall, taken, tgt};
    endtask

    vec_t        tbl[23];
    fs_to_ds_t   b, prev_b;
    logic [31:0] exp_pc, tgt;
    logic        allow, stall, taken, hold_prev;
    int          stall_left, deliveries;

    initial begin
        // mask bits: 0 en, 1 addr, 2 valid, 3 pc+adef, 4 inst
        tbl[0]  = v(0,1,0,0,0,            5'b01101, 0, 0,           0, 32'h1bfffffc, 0, 0);
        tbl[1]  = v(1,1,0,0,0,            5'b00101, 0, 0,           0, 0, 0, 0);
        tbl[2]  = v(1,1,0,0,0,            5'b00111, 1, R,           0, 0, 0, 0);
        tbl[3]  = v(1,1,0,0,0,            5'b11111, 1, R+4,         1, R, R, 0);
        tbl[4]  = v(1,0,0,0,0,            5'b11111, 0, R+8,         1, R+4, R+4, 0);
        tbl[5]  = v(1,0,0,0,0,            5'b11101, 0, 0,           1, R+4, R+4, 0);
        tbl[6]  = v(1,0,0,0,0,            5'b11101, 0, 0,           1, R+4, R+4, 0);
        tbl[7]  = v(1,1,0,0,0,            5'b11111, 1, R+8,         1, R+4, R+4, 0);
        tbl[8]  = v(1,1,0,1,R+32'h100,    5'b01111, 1, R+32'h100,   0, R+8, 0, 0);
        tbl[9]  = v(1,1,0,0,0,            5'b11111, 1, R+32'h104,   1, R+32'h100, R+32'h100, 0);
        tbl[10] = v(1,1,1,0,0,            5'b11101, 0, 0,           1, R+32'h104, R+32'h104, 0);
        tbl[11] = v(1,1,1,1,R+32'h200,    5'b00101, 0, 0,           0, 0, 0, 0);
        tbl[12] = v(1,1,0,0,0,            5'b00111, 1, R+32'h200,   0, 0, 0, 0);
        tbl[13] = v(1,1,0,0,0,            5'b11111, 1, R+32'h204,   1, R+32'h200, R+32'h200, 0);
        tbl[14] = v(1,1,0,1,R+32'h102,    5'b00111, 0, R+32'h102,   0, 0, 0, 0);
        tbl[15] = v(1,0,0,0,0,            5'b11111, 0, R+32'h106,   1, R+32'h102, 0, 1);
        tbl[16] = v(0,0,0,0,0,            5'b01101, 0, 0,           0, 32'h1bfffffc, 0, 0);
        tbl[17] = v(1,1,0,0,0,            5'b00101, 0, 0,           0, 0, 0, 0);
        tbl[18] = v(1,1,0,0,0,            5'b00111, 1, R,           0, 0, 0, 0);
        tbl[19] = v(1,1,0,0,0,            5'b11111, 1, R+4,         1, R, R, 0);
        tbl[20] = v(1,1,0,1,32'hfffffffc, 5'b00111, 1, 32'hfffffffc, 0, 0, 0, 0);
        tbl[21] = v(1,1,0,0,0,            5'b11111, 1, 32'h0,       1, 32'hfffffffc, 32'hfffffffc, 0);
        tbl[22] = v(1,1,0,0,0,            5'b11111, 1, 32'h4,       1, 32'h0, 32'h0, 0);

        drive(1, 0, 0, 0);
        #2;
        chk("reset we", bus_if.inst_sram_we, 0);
        chk("reset wdata", bus_if.inst_sram_wdata, 0);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            resetn = tbl[i].rst_n;
            drive(tbl[i].allow, tbl[i].stall, tbl[i].taken, tbl[i].target);
            #1;
            b = fs_to_ds_t'(bus_if.fs_to_ds_bus);
            if (tbl[i].m[0]) chk($sformatf("row%0d en", i), bus_if.inst_sram_en, tbl[i].en);
            if (tbl[i].m[1]) chk($sformatf("row%0d addr", i), bus_if.inst_sram_addr, tbl[i].addr);
            if (tbl[i].m[2]) chk($sformatf("row%0d valid", i), bus_if.fs_to_ds_valid, tbl[i].valid);
            if (tbl[i].m[3]) chk($sformatf("row%0d pc", i), b.pc, tbl[i].pc);
            if (tbl[i].m[3]) chk($sformatf("row%0d adef", i), b.adef, tbl[i].adef);
            if (tbl[i].m[4]) chk($sformatf("row%0d inst", i), b.inst, tbl[i].inst);
        end

        // randomized run: instructions delivered to ID must follow program order,
        // restarting at every branch target, with the SRAM data that belongs to each PC
        @(negedge clk);
        resetn = 1'b0;
        drive(1, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;
        exp_pc = R;
        stall_left = 0;
        deliveries = 0;
        hold_prev = 1'b0;
        prev_b = '0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            allow = ($urandom_range(3) != 0);
            if (stall_left > 0) begin
                stall = 1'b1;
                stall_left--;
            end else begin
                stall = 1'b0;
                if ($urandom_range(19) == 0) stall_left = $urandom_range(3, 1);
            end
            taken = ($urandom_range(15) == 0);
            tgt = {16'h1c00, 14'($urandom), ($urandom_range(7) == 0) ? 2'($urandom_range(3, 1)) : 2'b00};
            drive(allow, stall, taken, tgt);
            #1;
            b = fs_to_ds_t'(bus_if.fs_to_ds_bus);
            if (taken) begin
                chk("rnd squash valid", bus_if.fs_to_ds_valid, 0);
                exp_pc = tgt;
            end else if (bus_if.fs_to_ds_valid && allow) begin
                deliveries++;
                chk("rnd pc", b.pc, exp_pc);
                chk("rnd adef", b.adef, exp_pc[1:0] != 2'b00);
                chk("rnd inst", b.inst, (exp_pc[1:0] != 2'b00) ? 32'b0 : exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
            if (hold_prev && !taken) begin
                chk("rnd hold valid", bus_if.fs_to_ds_valid, 1);
                chk("rnd hold bus", b, prev_b);
            end
            if (bus_if.fs_to_ds_valid && !allow) chk("rnd backpressure en", bus_if.inst_sram_en, 0);
            if (stall) chk("rnd stall en", bus_if.inst_sram_en, 0);
            if (bus_if.inst_sram_en) chk("rnd en aligned", bus_if.inst_sram_addr[1:0], 0);
            hold_prev = bus_if.fs_to_ds_valid & ~allow;
            prev_b = b;
        end
        chk("rnd liveness", deliveries > 1000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
